// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage pipelined unsigned multiplier. Each beat picks its own mode:
// exact (a*b) or lower-part-OR approximate. In approximate mode the low APPROX_COLS
// product columns are the OR of their partial products and produce no carry. The
// columns above them are summed exactly.
//
// Optional feature, enabled by the macro APPROX_MULT_ERRSTAT_EN: on-line error
// statistics (stat_clr, err_count, err_sum). When the macro is undefined, these ports
// and all of their logic are absent.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_ready = out_ready | ~out_valid
//   in_a, in_b           WIDTH-bit unsigned operands
//   in_mode              1 = approximate, 0 = exact
//   in_tag               sideband tag, carried unchanged to out_tag
//   out_valid/out_ready  result handshake
//   out_p, out_tag, out_mode  result (2*WIDTH bits), its tag and its mode
//   stat_clr             clear both statistics counters (optional feature only)
//   err_count, err_sum   saturating error statistics (optional feature only)
module approx_mult_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_COLS = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_mode
`ifdef APPROX_MULT_ERRSTAT_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        err_count,
  output logic [31:0]        err_sum
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  // One global advance for the whole pipeline. Bubbles travel along and are not squeezed out.
  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // S1: partial-product matrix, one row per bit of b.
  logic [WIDTH-1:0] r_s1_pp [WIDTH];
  logic             r_s1_valid;
  logic             r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_tag   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) r_s1_pp[i] <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= in_mode;
      r_s1_tag   <= in_tag;
      for (int unsigned i = 0; i < WIDTH; i++) r_s1_pp[i] <= in_a & {WIDTH{in_b[i]}};
    end
  end

  // Reduce the matrix to a sum/carry pair using a chain of 3:2 compressors.
  // In approximate mode the rows are masked above the OR region before reduction.
  // Carries only move left, so nothing can leak back into the OR region.
  // Bitwise OR of the shifted rows is exactly the per-column OR.
  logic [PW-1:0] w_low_mask;
  logic [PW-1:0] w_sum;
  logic [PW-1:0] w_carry;
  logic [PW-1:0] w_low;
`ifdef APPROX_MULT_ERRSTAT_EN
  logic [PW-1:0] w_esum;
  logic [PW-1:0] w_ecarry;
`endif

  always_comb begin
    logic [PW-1:0] row;
    logic [PW-1:0] row_m;
    w_low_mask = '0;
    w_sum      = '0;
    w_carry    = '0;
    w_low      = '0;
    row        = '0;
    row_m      = '0;
`ifdef APPROX_MULT_ERRSTAT_EN
    w_esum     = '0;
    w_ecarry   = '0;
`endif
    for (int unsigned c = 0; c < PW; c++) w_low_mask[c] = (c < APPROX_COLS);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row   = PW'(r_s1_pp[i]) << i;
      w_low = w_low | row;
      row_m = r_s1_mode ? (row & ~w_low_mask) : row;
      // The final carry-out at the MSB can be dropped safely: the true total fits in PW bits.
      {w_carry, w_sum} = {((w_sum & w_carry) | (w_sum & row_m) | (w_carry & row_m)) << 1,
                          w_sum ^ w_carry ^ row_m};
`ifdef APPROX_MULT_ERRSTAT_EN
      {w_ecarry, w_esum} = {((w_esum & w_ecarry) | (w_esum & row) | (w_ecarry & row)) << 1,
                            w_esum ^ w_ecarry ^ row};
`endif
    end
    w_low = w_low & w_low_mask & {PW{r_s1_mode}};
  end

  // S2: two-row form with the low OR bits resolved.
  logic [PW-1:0]    r_s2_sum;
  logic [PW-1:0]    r_s2_carry;
  logic [PW-1:0]    r_s2_low;
  logic             r_s2_valid;
  logic             r_s2_mode;
  logic [TAG_W-1:0] r_s2_tag;
`ifdef APPROX_MULT_ERRSTAT_EN
  logic [PW-1:0]    r_s2_esum;
  logic [PW-1:0]    r_s2_ecarry;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_sum    <= '0;
      r_s2_carry  <= '0;
      r_s2_low    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_mode   <= 1'b0;
      r_s2_tag    <= '0;
`ifdef APPROX_MULT_ERRSTAT_EN
      r_s2_esum   <= '0;
      r_s2_ecarry <= '0;
`endif
    end else if (w_adv) begin
      r_s2_sum    <= w_sum;
      r_s2_carry  <= w_carry;
      r_s2_low    <= w_low;
      r_s2_valid  <= r_s1_valid;
      r_s2_mode   <= r_s1_mode;
      r_s2_tag    <= r_s1_tag;
`ifdef APPROX_MULT_ERRSTAT_EN
      r_s2_esum   <= w_esum;
      r_s2_ecarry <= w_ecarry;
`endif
    end
  end

  // S3: final sum. The OR field and the summed field never overlap.
  logic [PW-1:0]    r_s3_p;
  logic             r_s3_valid;
  logic             r_s3_mode;
  logic [TAG_W-1:0] r_s3_tag;
`ifdef APPROX_MULT_ERRSTAT_EN
  logic [PW-1:0]    r_s3_exact;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_p     <= '0;
      r_s3_valid <= 1'b0;
      r_s3_mode  <= 1'b0;
      r_s3_tag   <= '0;
`ifdef APPROX_MULT_ERRSTAT_EN
      r_s3_exact <= '0;
`endif
    end else if (w_adv) begin
      r_s3_p     <= (r_s2_sum + r_s2_carry) | r_s2_low;
      r_s3_valid <= r_s2_valid;
      r_s3_mode  <= r_s2_mode;
      r_s3_tag   <= r_s2_tag;
`ifdef APPROX_MULT_ERRSTAT_EN
      r_s3_exact <= r_s2_esum + r_s2_ecarry;
`endif
    end
  end

  assign out_valid = r_s3_valid;
  assign out_p     = r_s3_p;
  assign out_tag   = r_s3_tag;
  assign out_mode  = r_s3_mode;

`ifdef APPROX_MULT_ERRSTAT_EN
  // The accumulator is wide enough to hold a full-width difference plus a carry.
  localparam int unsigned SW = ((PW > 32) ? PW : 32) + 1;

  logic [31:0]   r_err_count;
  logic [31:0]   r_err_sum;
  logic [PW-1:0] w_diff;
  logic [SW-1:0] w_acc;
  logic          w_err;

  // approx <= exact always holds, so the difference cannot wrap.
  assign w_diff = r_s3_exact - r_s3_p;
  assign w_err  = r_s3_valid & out_ready & r_s3_mode & (w_diff != '0);
  assign w_acc  = SW'(r_err_sum) + SW'(w_diff);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_err_count <= '0;
      r_err_sum   <= '0;
    end else if (w_err) begin
      if (r_err_count != '1) r_err_count <= r_err_count + 32'd1;
      r_err_sum <= (w_acc[SW-1:32] != '0) ? '1 : w_acc[31:0];
    end
  end

  assign err_count = r_err_count;
  assign err_sum   = r_err_sum;
`endif

endmodule
